// File: rtl/tz_offset_ctrl.sv
// tz_offset_ctrl -- button-driven time-zone offset controller.
//
// Holds an NZONES-entry table of hour/minute offsets. Three buttons select a
// zone and edit its offsets; the active zone's offset drives the clock chain.
//
// Optional feature macro: TZ_AUTOREPEAT_EN. When defined, holding up or down
// (alone) in an edit state produces synthetic steps after REPEAT_DELAY cycles
// and then every REPEAT_CYCLES. When undefined, one step per rising edge.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-low reset
//   btn_mode     mode button (synchronised level)
//   btn_up       up button (synchronised level)
//   btn_down     down button (synchronised level)
//   zone_sel     index of the active zone
//   offset_hours active zone hour offset, 0..23
//   offset_mins  active zone minute offset, 0..59
//   edit_state   00 RUN, 01 SEL_ZONE, 10 EDIT_HR, 11 EDIT_MIN
//   apply        one-cycle pulse whenever offset_hours/offset_mins change
//   blink        field-blink for the display while editing
module tz_offset_ctrl #(
  parameter int  NZONES         = 4,
  parameter int  TIMEOUT_CYCLES = 50_000_000,
  parameter int  BLINK_CYCLES   = 12_500_000,
  parameter int  REPEAT_DELAY   = 25_000_000,
  parameter int  REPEAT_CYCLES  = 5_000_000,
  localparam int ZW             = $clog2(NZONES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          btn_mode,
  input  logic          btn_up,
  input  logic          btn_down,
  output logic [ZW-1:0] zone_sel,
  output logic [4:0]    offset_hours,
  output logic [5:0]    offset_mins,
  output logic [1:0]    edit_state,
  output logic          apply,
  output logic          blink
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(BLINK_CYCLES + 1);

  if (NZONES < 2 || TIMEOUT_CYCLES < 2 || BLINK_CYCLES < 1 ||
      REPEAT_DELAY < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
    $error("tz_offset_ctrl: invalid parameter values");
  end

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SEL_ZONE = 2'b01,
    EDIT_HR  = 2'b10,
    EDIT_MIN = 2'b11
  } state_e;

  state_e                   state_q, state_d;
  logic [2:0]               prev_q, pulse_q;   // bit order {mode, up, down}
  logic [ZW-1:0]            zone_q, zone_d;
  logic [NZONES-1:0][4:0]   hr_q, hr_d;
  logic [NZONES-1:0][5:0]   min_q, min_d;
  logic [4:0]               ohr_q, ohr_d;
  logic [5:0]               omin_q, omin_d;
  logic                     apply_q, apply_d;
  logic                     blink_q, blink_d;
  logic [TW-1:0]            idle_q, idle_d;
  logic [BW-1:0]            bcnt_q, bcnt_d;
  logic [2:0]               btn_v;
  logic                     mode_p, up_p, dn_p, step_up, step_dn, accepted;

  assign btn_v = {btn_mode, btn_up, btn_down};

  // mode wins over up/down; up and down together cancel
  assign mode_p = pulse_q[2];
  assign up_p   = pulse_q[1] & ~pulse_q[2] & ~pulse_q[0];
  assign dn_p   = pulse_q[0] & ~pulse_q[2] & ~pulse_q[1];

  // History resets to 1 so a button held through reset release never fires.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q  <= 3'b111;
      pulse_q <= 3'b000;
    end else begin
      prev_q  <= btn_v;
      pulse_q <= btn_v & ~prev_q;
    end
  end

`ifdef TZ_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_CYCLES) ? REPEAT_DELAY : REPEAT_CYCLES;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          rarm_q, rarm_d;     // a real up/down step armed repeat
  logic          rphase_q, rphase_d; // 0: initial delay, 1: repeat interval
  logic          rdir_q, rdir_d;     // 1: up, 0: down
  logic          held, rep_step;

  always_comb begin
    rcnt_d   = rcnt_q;
    rarm_d   = rarm_q;
    rphase_d = rphase_q;
    rdir_d   = rdir_q;
    rep_step = 1'b0;
    held     = rdir_q ? (btn_up & ~btn_down) : (btn_down & ~btn_up);
    if (state_q == RUN || mode_p) begin
      rarm_d = 1'b0;
    end else if (up_p || dn_p) begin
      rarm_d   = 1'b1;
      rdir_d   = up_p;
      rcnt_d   = '0;
      rphase_d = 1'b0;
    end else if (rarm_q) begin
      if (!held) begin
        rarm_d = 1'b0;
      end else if (rcnt_q == (rphase_q ? RW'(REPEAT_CYCLES - 1) : RW'(REPEAT_DELAY - 1))) begin
        rep_step = 1'b1;
        rcnt_d   = '0;
        rphase_d = 1'b1;
      end else begin
        rcnt_d = rcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rcnt_q   <= '0;
      rarm_q   <= 1'b0;
      rphase_q <= 1'b0;
      rdir_q   <= 1'b0;
    end else begin
      rcnt_q   <= rcnt_d;
      rarm_q   <= rarm_d;
      rphase_q <= rphase_d;
      rdir_q   <= rdir_d;
    end
  end

  assign step_up = up_p | (rep_step & rdir_q);
  assign step_dn = dn_p | (rep_step & ~rdir_q);
`else
  assign step_up = up_p;
  assign step_dn = dn_p;
`endif

  assign accepted = mode_p | step_up | step_dn;

  always_comb begin
    state_d = state_q;
    zone_d  = zone_q;
    hr_d    = hr_q;
    min_d   = min_q;
    idle_d  = idle_q;
    bcnt_d  = bcnt_q;
    blink_d = blink_q;
    unique case (state_q)
      RUN: if (mode_p) state_d = SEL_ZONE;
      SEL_ZONE: begin
        if (mode_p)       state_d = EDIT_HR;
        else if (step_up) zone_d  = (zone_q == ZW'(NZONES - 1)) ? '0 : zone_q + 1'b1;
        else if (step_dn) zone_d  = (zone_q == '0) ? ZW'(NZONES - 1) : zone_q - 1'b1;
      end
      EDIT_HR: begin
        if (mode_p)       state_d = EDIT_MIN;
        else if (step_up) hr_d[zone_q] = (hr_q[zone_q] == 5'd23) ? 5'd0 : hr_q[zone_q] + 5'd1;
        else if (step_dn) hr_d[zone_q] = (hr_q[zone_q] == 5'd0) ? 5'd23 : hr_q[zone_q] - 5'd1;
      end
      EDIT_MIN: begin
        if (mode_p)       state_d = RUN;
        else if (step_up) min_d[zone_q] = (min_q[zone_q] == 6'd59) ? 6'd0 : min_q[zone_q] + 6'd1;
        else if (step_dn) min_d[zone_q] = (min_q[zone_q] == 6'd0) ? 6'd59 : min_q[zone_q] - 6'd1;
      end
      default: state_d = RUN;
    endcase

    // idle timeout; a button step on the same edge takes precedence
    if (state_q != RUN && !accepted && idle_q == TW'(TIMEOUT_CYCLES - 1))
      state_d = RUN;

    if (state_d == RUN || accepted || state_d != state_q) idle_d = '0;
    else                                                  idle_d = idle_q + 1'b1;

    if (state_d == RUN) begin
      blink_d = 1'b0;
      bcnt_d  = '0;
    end else if (state_d != state_q) begin
      bcnt_d = '0;
    end else if (bcnt_q == BW'(BLINK_CYCLES - 1)) begin
      blink_d = ~blink_q;
      bcnt_d  = '0;
    end else begin
      bcnt_d = bcnt_q + 1'b1;
    end
  end

  // outputs track the post-edge table/zone so they move on the same edge
  assign ohr_d   = hr_d[zone_d];
  assign omin_d  = min_d[zone_d];
  assign apply_d = (ohr_d != ohr_q) || (omin_d != omin_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      zone_q  <= '0;
      hr_q    <= '0;
      min_q   <= '0;
      ohr_q   <= '0;
      omin_q  <= '0;
      apply_q <= 1'b0;
      blink_q <= 1'b0;
      idle_q  <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      zone_q  <= zone_d;
      hr_q    <= hr_d;
      min_q   <= min_d;
      ohr_q   <= ohr_d;
      omin_q  <= omin_d;
      apply_q <= apply_d;
      blink_q <= blink_d;
      idle_q  <= idle_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign zone_sel     = zone_q;
  assign offset_hours = ohr_q;
  assign offset_mins  = omin_q;
  assign edit_state   = state_q;
  assign apply        = apply_q;
  assign blink        = blink_q;

endmodule

// File: doc/tz_offset_ctrl.md
Name: tz_offset_ctrl

Overview:
- Button-driven time-zone offset controller for the world clock.
- Holds a small table of per-zone hour/minute offsets and lets the user select and edit zones with three buttons.
- Drives the offset_hours/offset_mins inputs of the 24-hour clock chain with the active zone's offset.
- Provides edit-state and blink outputs for the display layer.

Parameters:
- NZONES, 4, number of zone entries; must be ≥2; zone_sel width ZW = $clog2(NZONES).
- TIMEOUT_CYCLES, 50_000_000, idle cycles in any edit state before automatic return to RUN.
- BLINK_CYCLES, 12_500_000, half-period of the blink output in edit states.
- REPEAT_DELAY, 25_000_000, hold cycles before auto-repeat starts (used only with TZ_AUTOREPEAT_EN).
- REPEAT_CYCLES, 5_000_000, auto-repeat step interval (used only with TZ_AUTOREPEAT_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- btn_mode  in  1  mode button, level, already synchronised.
- btn_up  in  1  up button, level, already synchronised.
- btn_down  in  1  down button, level, already synchronised.
- zone_sel  out  ZW  index of the active zone.
- offset_hours  out  5  active zone hour offset, 0..23.
- offset_mins  out  6  active zone minute offset, 0..59.
- edit_state  out  2  00 RUN, 01 SEL_ZONE, 10 EDIT_HR, 11 EDIT_MIN.
- apply  out  1  one-cycle pulse coincident with any change of offset_hours/offset_mins.
- blink  out  1  field-blink for the display.

Behaviour:
- Reset (reset=0, async):
  - state RUN; zone_sel=0; every table entry hr=0, min=0.
  - offset_hours=0, offset_mins=0, apply=0, blink=0; all counters 0.
  - Button-history registers reset to 1, so a button held through reset release does not fire.
- Edge detect:
  - Registered rising-edge pulse per button: pulse_x = btn_x & ~prev_x, registered.
  - Action is taken on the clock edge after the pulse register sets, i.e. 2 clock edges after the button is first sampled high.
- Priority on simultaneous pulses:
  - mode beats up/down; up/down pulses in the same cycle as mode are discarded.
  - up and down together are ignored.
- FSM:
  - RUN: mode -> SEL_ZONE. up/down ignored.
  - SEL_ZONE: up -> zone_sel+1, wrapping NZONES-1 -> 0. down -> zone_sel-1, wrapping 0 -> NZONES-1. mode -> EDIT_HR.
  - EDIT_HR: up -> table[zone_sel].hr+1, wrapping 23 -> 0. down -> hr-1, wrapping 0 -> 23. mode -> EDIT_MIN.
  - EDIT_MIN: up -> min+1, wrapping 59 -> 0. down -> min-1, wrapping 0 -> 59. mode -> RUN.
- Timeout:
  - Idle counter clears on any accepted button pulse and on every state change.
  - In SEL_ZONE, EDIT_HR or EDIT_MIN, reaching TIMEOUT_CYCLES-1 -> RUN. Edits already made are kept.
  - Counter is held at 0 in RUN.
- Outputs:
  - offset_hours/offset_mins are registered and always equal table[zone_sel], updated on the same edge as the table or zone_sel change.
  - apply=1 for exactly that cycle when either value differs from its previous value; otherwise 0.
  - A zone change to an entry with identical offsets gives no apply.
- Blink:
  - Toggles every BLINK_CYCLES while not in RUN.
  - Forced to 0 and its counter cleared on entry to RUN.
  - Its counter restarts at 0 on every state change.
- Table width rules: hr stored in 5 bits, min in 6 bits; values outside 0..23 / 0..59 are never produced.
- Reset mid-edit: immediate return to RUN with all table entries cleared to 0.

Optional Feature:
- Macro: TZ_AUTOREPEAT_EN.
- Defined:
  - In SEL_ZONE, EDIT_HR and EDIT_MIN, holding up (or down, alone) for REPEAT_DELAY cycles after its pulse generates a synthetic step.
  - Further steps follow every REPEAT_CYCLES while held. Release or a state change stops repeat.
  - Each synthetic step is treated as a button pulse: it clears the timeout counter and obeys the same wrap rules.
- Not defined: one step per rising edge only; REPEAT_* parameters unused.

Test Plan:
- Reset check: assert reset=0 mid-cycle -> all outputs 0 asynchronously; release with btn_up held high -> no step, edit_state stays 00.
- Zone select and minute wrap: mode, up, up, mode, mode, down -> zone_sel=2, zone2 min=59, offset_mins=59 with a single apply pulse; then mode -> edit_state 00.
- Hour wrap: in EDIT_HR on zone0, press up 24 times -> offset_hours counts to 23 then returns 0; apply pulses 24 times.
- Simultaneous presses: in EDIT_HR, up+down same cycle -> no change; mode+up same cycle -> edit_state 11, hr unchanged.
- Timeout and blink (TIMEOUT_CYCLES=20, BLINK_CYCLES=4): enter EDIT_HR, idle -> RUN after 20 cycles; blink toggles every 4 cycles meanwhile, then 0.
- Auto-repeat (TZ_AUTOREPEAT_EN, REPEAT_DELAY=10, REPEAT_CYCLES=3): hold up 20 cycles in EDIT_MIN from 0 -> min=1 at press, 2 at +10, then 3, 4, 5 at +13/+16/+19; macro off -> min=1.
